// File: rtl/aes_key_scheduler.sv
// AES key expansion (FIPS-197) for 128/192/256-bit keys, one word per cycle, with an
// external combinational S-box and a registered round-key read port.
module aes_key_scheduler #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10,
  localparam int unsigned Nkb = Nk * 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [0:Nkb-1] key,
  output logic           busy,
  output logic           key_ready,
  output logic [0:31]    sw_in,
  input  logic [0:31]    sw_out,
  input  logic           rk_rd,
  input  logic [3:0]     rk_idx,
  output logic           rk_valid,
  output logic [0:127]   rk_data,
  output logic           rk_err
);

  localparam int unsigned NumW = 4 * (Nr + 1);
  localparam int unsigned IdxW = 6;

  if (!((Nk == 4) || (Nk == 6) || (Nk == 8)) || (Nr != Nk + 6)) begin : g_bad_param
    $error("aes_key_scheduler: illegal Nk/Nr combination");
  end

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   i_q, i_d;
  // Tracks i mod Nk so the non-power-of-two Nk=6 case needs no divider.
  logic [2:0]        j_q, j_d;
  logic [7:0]        rcon_q, rcon_d;
  logic              busy_q, busy_d;
  logic              key_ready_q, key_ready_d;
  logic              rk_valid_q, rk_valid_d;
  logic              rk_err_q, rk_err_d;
  logic [0:127]      rk_data_q, rk_data_d;

  logic [0:31]       w_q [NumW];

  logic [IdxW-1:0]   prev_addr, old_addr, rd_base;
  logic [0:31]       prev_w, old_w, temp_w, new_w;
  logic              rot_sel, sub_sel, last_word;
  logic              load_key, w_we, rd_ok;

  always_comb begin
    prev_addr = (state_q == StExpand) ? i_q - 6'd1 : '0;
    old_addr  = (state_q == StExpand) ? i_q - 6'(Nk) : '0;
    prev_w    = w_q[prev_addr];
    old_w     = w_q[old_addr];
    rot_sel   = (j_q == 3'd0);
    sub_sel   = (Nk == 8) && (j_q == 3'd4);
    last_word = (i_q == 6'(NumW - 1));

    if (state_q == StExpand) begin
      sw_in = rot_sel ? {prev_w[8:31], prev_w[0:7]} : prev_w;
    end else begin
      sw_in = '0;
    end

    if (rot_sel) begin
      temp_w = sw_out ^ {rcon_q, 24'h000000};
    end else if (sub_sel) begin
      temp_w = sw_out;
    end else begin
      temp_w = prev_w;
    end
    new_w = old_w ^ temp_w;
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    rcon_d   = rcon_q;
    load_key = 1'b0;
    w_we     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StExpand;
          i_d      = 6'(Nk);
          j_d      = 3'd0;
          rcon_d   = 8'h01;
          load_key = 1'b1;
        end
      end
      StExpand: begin
        w_we = 1'b1;
        i_d  = i_q + 6'd1;
        j_d  = (j_q == 3'(Nk - 1)) ? 3'd0 : j_q + 3'd1;
        if (rot_sel) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (last_word) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d      = (state_d == StExpand);
    key_ready_d = (state_d == StDone);
  end

  // Reads sample the buffer before this edge's writes, so a read that coincides with a
  // restart still returns the previous key schedule.
  always_comb begin
    rd_ok      = rk_rd && (state_q == StDone) && (rk_idx <= 4'(Nr));
    rd_base    = rd_ok ? {rk_idx, 2'b00} : '0;
    rk_valid_d = rd_ok;
    rk_err_d   = rk_rd && !rd_ok;
    if (rd_ok) begin
      rk_data_d = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end else begin
      rk_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_err_q    <= 1'b0;
      rk_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      rk_err_q    <= rk_err_d;
      rk_data_q   <= rk_data_d;
    end
  end

  // Word buffer carries no reset; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_key) begin
        for (int unsigned k = 0; k < Nk; k++) begin
          w_q[k] <= key[k*32 +: 32];
        end
      end else if (w_we) begin
        w_q[i_q] <= new_w;
      end
    end
  end

  assign busy      = busy_q;
  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_err    = rk_err_q;
  assign rk_data   = rk_data_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Bench for aes_key_scheduler: Nk=4 and Nk=8 instances, an S-box model, a reference key
// expansion and a read scoreboard.
module tb_aes_key_scheduler;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KX = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [255:0] K8 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct packed {
    logic         v;
    logic         e;
    logic [127:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic         rst;
  logic         k4_start, k4_busy, k4_ready, k4_rd, k4_valid, k4_err;
  logic [0:127] k4_key;
  logic [0:31]  k4_sw_in, k4_sw_out;
  logic [3:0]   k4_idx;
  logic [0:127] k4_data;
  logic         k8_start, k8_busy, k8_ready, k8_rd, k8_valid, k8_err;
  logic [0:255] k8_key;
  logic [0:31]  k8_sw_in, k8_sw_out;
  logic [3:0]   k8_idx;
  logic [0:127] k8_data;

  logic [31:0] mw [60];
  exp_t        sb [$];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = x; r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign k4_sw_out = subw(k4_sw_in);
  assign k8_sw_out = subw(k8_sw_in);

  task automatic model_expand(input int nk, input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int idx);
    return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
  endfunction

  aes_key_scheduler #(.Nk(4), .Nr(10)) dut4 (
    .clk(clk), .rst(rst), .start(k4_start), .key(k4_key), .busy(k4_busy),
    .key_ready(k4_ready), .sw_in(k4_sw_in), .sw_out(k4_sw_out), .rk_rd(k4_rd),
    .rk_idx(k4_idx), .rk_valid(k4_valid), .rk_data(k4_data), .rk_err(k4_err)
  );

  aes_key_scheduler #(.Nk(8), .Nr(14)) dut8 (
    .clk(clk), .rst(rst), .start(k8_start), .key(k8_key), .busy(k8_busy),
    .key_ready(k8_ready), .sw_in(k8_sw_in), .sw_out(k8_sw_out), .rk_rd(k8_rd),
    .rk_idx(k8_idx), .rk_valid(k8_valid), .rk_data(k8_data), .rk_err(k8_err)
  );

  task automatic do_start4(input logic [127:0] k);
    k4_key = k; k4_start = 1'b1;
    @(posedge clk); #1;
    k4_start = 1'b0;
  endtask

  task automatic wait_ready4(output int n, output int busy_bad);
    n = 0; busy_bad = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (k4_ready === 1'b1) break;
      if (k4_busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; k4_start = 1'b1; k4_rd = 1'b1; k4_idx = 4'd0; k4_key = K1;
    k8_start = 1'b1; k8_rd = 1'b1; k8_idx = 4'd0; k8_key = K8;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (k4_busy !== 1'b0 || k4_ready !== 1'b0)
      begin n_fail++; $display("FAIL reset_status: busy=%b ready=%b, want 0 0", k4_busy, k4_ready); end
    n_tests++;
    if (k4_valid !== 1'b0 || k4_err !== 1'b0 || k4_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_read: v=%b e=%b d=%h, want 0 0 0", k4_valid, k4_err, k4_data);
    end
    n_tests++;
    if (k8_busy !== 1'b0 || k8_ready !== 1'b0 || k8_valid !== 1'b0 || k8_err !== 1'b0)
      begin n_fail++; $display("FAIL reset_nk8: busy=%b ready=%b v=%b e=%b, want 0", k8_busy, k8_ready, k8_valid, k8_err); end
    rst = 1'b0; k4_start = 1'b0; k8_start = 1'b0; k8_rd = 1'b0;
    k4_rd = 1'b1; k4_idx = 4'd0;
    sb.push_back('{v: 1'b0, e: 1'b1, d: 128'h0});
    @(posedge clk); #1;
    e = sb.pop_front(); n_tests++;
    if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
      n_fail++;
      $display("FAIL read_not_ready: v=%b e=%b d=%h, want v=%b e=%b d=%h", k4_valid, k4_err, k4_data, e.v, e.e, e.d);
    end
    k4_rd = 1'b0;
  endtask

  task automatic test_fips_vector();
    int n, bb;
    exp_t e;
    int idxs [3];
    logic [127:0] vals [3];
    idxs = '{0, 1, 10};
    vals = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
             128'h13111d7fe3944a17f307a78b4d2b30c5};
    do_start4(K1);
    n_tests++;
    if (k4_busy !== 1'b1 || k4_ready !== 1'b0)
      begin n_fail++; $display("FAIL start_accept: busy=%b ready=%b, want 1 0", k4_busy, k4_ready); end
    wait_ready4(n, bb);
    n_tests++;
    if (n !== 40) begin n_fail++; $display("FAIL latency_nk4: got %0d edges, want 40", n); end
    n_tests++;
    if (bb !== 0 || k4_busy !== 1'b0)
      begin n_fail++; $display("FAIL busy_window: gaps=%0d busy_at_ready=%b, want 0 0", bb, k4_busy); end
    for (int k = 0; k < 3; k++) begin
      k4_rd = 1'b1; k4_idx = 4'(idxs[k]);
      sb.push_back('{v: 1'b1, e: 1'b0, d: vals[k]});
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
        n_fail++;
        $display("FAIL fips_idx%0d: v=%b e=%b d=%h, want v=%b e=%b d=%h", idxs[k], k4_valid, k4_err, k4_data, e.v, e.e, e.d);
      end
    end
    k4_rd = 1'b0;
  endtask

  task automatic test_sweep();
    int n, bb;
    exp_t e;
    model_expand(4, {K2, 128'h0});
    do_start4(K2);
    wait_ready4(n, bb);
    n_tests++;
    if (n !== 40) begin n_fail++; $display("FAIL latency_sweep: got %0d edges, want 40", n); end
    for (int k = 0; k <= 10; k++) begin
      k4_rd = 1'b1; k4_idx = 4'(k);
      sb.push_back('{v: 1'b1, e: 1'b0,
                     d: (k == 10) ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 : exp_rk(k)});
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
        n_fail++;
        $display("FAIL sweep_idx%0d: v=%b e=%b d=%h, want v=%b e=%b d=%h", k, k4_valid, k4_err, k4_data, e.v, e.e, e.d);
      end
    end
    k4_rd = 1'b0;
  endtask

  task automatic test_errors();
    int n, bb;
    exp_t e;
    int eidx [3];
    eidx = '{11, 15, 5};
    for (int k = 0; k < 3; k++) begin
      k4_rd = 1'b1; k4_idx = 4'(eidx[k]);
      if (eidx[k] <= 10) sb.push_back('{v: 1'b1, e: 1'b0, d: exp_rk(eidx[k])});
      else sb.push_back('{v: 1'b0, e: 1'b1, d: 128'h0});
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
        n_fail++;
        $display("FAIL range_idx%0d: v=%b e=%b d=%h, want v=%b e=%b d=%h", eidx[k], k4_valid, k4_err, k4_data, e.v, e.e, e.d);
      end
    end
    k4_rd = 1'b0;
    do_start4(K3);
    k4_rd = 1'b1; k4_idx = 4'd3;
    sb.push_back('{v: 1'b0, e: 1'b1, d: 128'h0});
    @(posedge clk); #1;
    e = sb.pop_front(); n_tests++;
    if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
      n_fail++;
      $display("FAIL read_during_expand: v=%b e=%b d=%h, want v=%b e=%b d=%h", k4_valid, k4_err, k4_data, e.v, e.e, e.d);
    end
    k4_rd = 1'b0;
    wait_ready4(n, bb);
    n_tests++;
    if (n !== 39) begin n_fail++; $display("FAIL latency_after_err: got %0d edges, want 39", n); end
  endtask

  task automatic test_start_ignored();
    int n, bb;
    exp_t e;
    model_expand(4, {K2, 128'h0});
    do_start4(K2);
    repeat (4) @(posedge clk);
    #1;
    k4_key = KX; k4_start = 1'b1;
    @(posedge clk); #1;
    k4_start = 1'b0;
    wait_ready4(n, bb);
    n_tests++;
    if (n !== 35) begin n_fail++; $display("FAIL latency_ignored_start: got %0d edges, want 35", n); end
    for (int k = 4; k <= 10; k += 6) begin
      k4_rd = 1'b1; k4_idx = 4'(k);
      sb.push_back('{v: 1'b1, e: 1'b0, d: exp_rk(k)});
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
        n_fail++;
        $display("FAIL ignored_start_idx%0d: v=%b e=%b d=%h, want v=%b e=%b d=%h", k, k4_valid, k4_err, k4_data, e.v, e.e, e.d);
      end
    end
    k4_rd = 1'b0;
  endtask

  task automatic test_reset_abort();
    int n, bb;
    exp_t e;
    do_start4(K1);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (k4_busy !== 1'b0 || k4_ready !== 1'b0)
      begin n_fail++; $display("FAIL reset_abort: busy=%b ready=%b, want 0 0", k4_busy, k4_ready); end
    model_expand(4, {K3, 128'h0});
    do_start4(K3);
    wait_ready4(n, bb);
    n_tests++;
    if (n !== 40) begin n_fail++; $display("FAIL latency_after_abort: got %0d edges, want 40", n); end
    for (int k = 0; k <= 10; k++) begin
      k4_rd = 1'b1; k4_idx = 4'(k);
      sb.push_back('{v: 1'b1, e: 1'b0, d: exp_rk(k)});
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
        n_fail++;
        $display("FAIL abort_idx%0d: v=%b e=%b d=%h, want v=%b e=%b d=%h", k, k4_valid, k4_err, k4_data, e.v, e.e, e.d);
      end
    end
    k4_rd = 1'b0;
  endtask

  task automatic test_read_restart();
    int n, bb;
    exp_t e;
    k4_rd = 1'b1; k4_idx = 4'd2; k4_key = K1; k4_start = 1'b1;
    sb.push_back('{v: 1'b1, e: 1'b0, d: exp_rk(2)});
    @(posedge clk); #1;
    k4_rd = 1'b0; k4_start = 1'b0;
    e = sb.pop_front(); n_tests++;
    if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
      n_fail++;
      $display("FAIL read_with_restart: v=%b e=%b d=%h, want v=%b e=%b d=%h", k4_valid, k4_err, k4_data, e.v, e.e, e.d);
    end
    n_tests++;
    if (k4_busy !== 1'b1 || k4_ready !== 1'b0)
      begin n_fail++; $display("FAIL restart_accept: busy=%b ready=%b, want 1 0", k4_busy, k4_ready); end
    wait_ready4(n, bb);
    n_tests++;
    if (n !== 40) begin n_fail++; $display("FAIL latency_restart: got %0d edges, want 40", n); end
    k4_rd = 1'b1; k4_idx = 4'd1;
    sb.push_back('{v: 1'b1, e: 1'b0, d: 128'hd6aa74fdd2af72fadaa678f1d6ab76fe});
    @(posedge clk); #1;
    k4_rd = 1'b0;
    e = sb.pop_front(); n_tests++;
    if (k4_valid !== e.v || k4_err !== e.e || k4_data !== e.d) begin
      n_fail++;
      $display("FAIL restart_new_key: v=%b e=%b d=%h, want v=%b e=%b d=%h", k4_valid, k4_err, k4_data, e.v, e.e, e.d);
    end
  endtask

  task automatic test_nk8();
    int n;
    exp_t e;
    model_expand(8, K8);
    k8_key = K8; k8_start = 1'b1;
    @(posedge clk); #1;
    k8_start = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (k8_ready === 1'b1) break;
    end
    n_tests++;
    if (n !== 52) begin n_fail++; $display("FAIL latency_nk8: got %0d edges, want 52", n); end
    for (int k = 0; k <= 14; k++) begin
      k8_rd = 1'b1; k8_idx = 4'(k);
      if (k == 14) sb.push_back('{v: 1'b1, e: 1'b0, d: 128'h24fc79ccbf0979e9371ac23c6d68de36});
      else if (k == 1) sb.push_back('{v: 1'b1, e: 1'b0, d: 128'h101112131415161718191a1b1c1d1e1f});
      else sb.push_back('{v: 1'b1, e: 1'b0, d: exp_rk(k)});
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (k8_valid !== e.v || k8_err !== e.e || k8_data !== e.d) begin
        n_fail++;
        $display("FAIL nk8_idx%0d: v=%b e=%b d=%h, want v=%b e=%b d=%h", k, k8_valid, k8_err, k8_data, e.v, e.e, e.d);
      end
    end
    k8_rd = 1'b1; k8_idx = 4'd15;
    sb.push_back('{v: 1'b0, e: 1'b1, d: 128'h0});
    @(posedge clk); #1;
    k8_rd = 1'b0;
    e = sb.pop_front(); n_tests++;
    if (k8_valid !== e.v || k8_err !== e.e || k8_data !== e.d) begin
      n_fail++;
      $display("FAIL nk8_idx15: v=%b e=%b d=%h, want v=%b e=%b d=%h", k8_valid, k8_err, k8_data, e.v, e.e, e.d);
    end
  endtask

  initial begin
    rst = 1'b1;
    k4_start = 1'b0; k4_key = '0; k4_rd = 1'b0; k4_idx = '0;
    k8_start = 1'b0; k8_key = '0; k8_rd = 1'b0; k8_idx = '0;
    test_reset();
    test_fips_vector();
    test_sweep();
    test_errors();
    test_start_ignored();
    test_reset_abort();
    test_read_restart();
    test_nk8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 Parameter Nk, default 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 Parameter Nr, default 10, number of rounds; SHALL equal Nk+6.
REQ-003 Localparam Nkb = Nk*32, key width in bits.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to expand key; sampled only in IDLE or DONE.
REQ-007 key  in  [0:Nkb-1]  cipher key, bit 0 = MSB of byte 0; sampled on the accepted start edge.
REQ-008 busy  out  1  expansion in progress.
REQ-009 key_ready  out  1  all 4*(Nr+1) words valid in the buffer.
REQ-010 sw_in  out  [0:31]  word presented to the external combinational S-box (SubWord).
REQ-011 sw_out  in  [0:31]  SubWord(sw_in), same cycle.
REQ-012 rk_rd  in  1  round-key read strobe.
REQ-013 rk_idx  in  4  round number 0..Nr to read.
REQ-014 rk_valid  out  1  rk_data valid, one-cycle pulse.
REQ-015 rk_data  out  [0:127]  round key = words w[4*idx]..w[4*idx+3], w[4*idx] in bits 0:31.
REQ-016 rk_err  out  1  one-cycle pulse: rejected read.

Function
REQ-017 States SHALL be IDLE, EXPAND, DONE.
REQ-018 IDLE/DONE + start: write key words into w[0..Nk-1], set counter i=Nk, Rcon=8'h01, enter EXPAND; key_ready falls the same edge.
REQ-019 EXPAND: one word per cycle; temp=w[i-1]; if i mod Nk==0: temp=SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon=xtime(Rcon) (0x80->0x1b); else if Nk==8 and i mod Nk==4: temp=SubWord(temp); w[i]=w[i-Nk]^temp; i++.
REQ-020 sw_in SHALL carry RotWord(w[i-1]) or w[i-1] as selected in REQ-019 during EXPAND; 0 otherwise.
REQ-021 After w[4*Nr+3] is written, next state DONE; busy=0, key_ready=1.
REQ-022 Latency: key_ready rises exactly 4*(Nr+1)-Nk edges after the accepted start edge (40 for Nk=4, 46 for Nk=6, 52 for Nk=8).
REQ-023 busy=1 exactly while in EXPAND.
REQ-024 start during EXPAND SHALL be ignored; expansion continues with the original key.
REQ-025 start in DONE restarts expansion with the new key; previous words are not readable once key_ready falls.
REQ-026 Read: rk_rd with key_ready=1 and rk_idx<=Nr -> next edge rk_valid=1, rk_data per REQ-015, rk_err=0.
REQ-027 rk_rd with key_ready=0 or rk_idx>Nr -> next edge rk_err=1, rk_valid=0, rk_data=0.
REQ-028 rk_rd and start on the same edge in DONE: read served from the old buffer; restart also accepted.
REQ-029 Back-to-back reads each cycle SHALL be served each cycle.
REQ-030 rk_data SHALL hold 0 whenever rk_valid=0.

Reset
REQ-031 rst=1 at an edge: state=IDLE, busy=0, key_ready=0, rk_valid=0, rk_err=0, rk_data=0, i=0, Rcon=8'h01; key buffer contents need not be cleared.
REQ-032 rst SHALL take priority over start and rk_rd on the same edge and abort an expansion mid-operation.

Verification
REQ-033 Nk=4, key=000102030405060708090a0b0c0d0e0f, start -> key_ready after 40 edges; read idx 0 = 000102030405060708090a0b0c0d0e0f, idx 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-034 Nk=4, key=2b7e151628aed2a6abf7158809cf4f3c -> idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; sweep idx 0..10 back-to-back, rk_valid each cycle.
REQ-035 Read idx 11 when ready -> rk_err pulse, rk_valid=0; read idx 3 during EXPAND -> rk_err pulse.
REQ-036 start pulsed at cycle 5 of EXPAND with a different key -> ignored; results match the first key.
REQ-037 rst at cycle 20 of EXPAND -> IDLE, busy=0, key_ready=0 next edge; new start yields correct keys after 40 edges.
REQ-038 Nk=8, Nr=14, key=000102...1e1f -> key_ready after 52 edges; idx 14 = 24fc79ccbf0979e9371ac23c6d68de36.
